// File: rtl/r2mdc_stage_ctrl.sv
// Per-stage sequencer for one R2MDC pipeline stage: input handshake, twiddle address,
// commutator selects, delay-line enable and output framing including the end-of-frame flush.
module r2mdc_stage_ctrl #(
   parameter int LOG2N = 4,
   parameter int STAGE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_sop,
   output logic             in_ready,
   output logic             bf_valid,
   output logic [LOG2N-2:0] tw_addr,
   output logic             in_sw_sel,
   output logic             dl_en,
   output logic             out_valid,
   output logic             out_sop,
   output logic             out_last,
   output logic             out_sw_sel,
   output logic             err
);

   localparam int W  = LOG2N - 1;
   localparam int D  = 2 ** (LOG2N - STAGE - 1);
   localparam int SB = LOG2N - STAGE - 1;

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] DMAX = W'(D);
   localparam logic [W-1:0] DM1  = W'(D - 1);
   localparam logic [W-1:0] PM1  = W'((2 ** W) - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      RUN,
      FLUSH
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   cnt, cnt_n;
   logic [W-1:0]   fill, fill_n;
   logic [W-1:0]   j, j_n;
   logic [W-1:0]   fcnt, fcnt_n;

   logic           accept;
   logic           issue;
   logic           emit;
   logic           flush;

   logic           bf_valid_n;
   logic [W-1:0]   tw_addr_n;
   logic           in_sw_sel_n;
   logic           dl_en_n;
   logic           out_valid_n;
   logic           out_sop_n;
   logic           out_last_n;
   logic           out_sw_sel_n;
   logic           err_n;

   assign in_ready = (state != FLUSH);
   assign accept   = in_valid & in_ready;

   // issue: an accepted pair enters the butterfly; emit: one output pair leaves the stage.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      fill_n  = fill;
      fcnt_n  = fcnt;
      issue   = 1'b0;
      emit    = 1'b0;
      flush   = 1'b0;
      err_n   = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               if (in_sop) begin
                  issue   = 1'b1;
                  cnt_n   = ONE;
                  fill_n  = ONE;
                  state_n = (D == 1) ? RUN : FILL;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         FILL: begin
            if (accept) begin
               issue  = 1'b1;
               err_n  = in_sop;
               cnt_n  = cnt + ONE;
               fill_n = fill + ONE;
               if ((fill + ONE) == DMAX) begin
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            if (accept) begin
               issue = 1'b1;
               emit  = 1'b1;
               err_n = in_sop;
               if (cnt == PM1) begin
                  cnt_n   = '0;
                  fcnt_n  = '0;
                  state_n = FLUSH;
               end else begin
                  cnt_n = cnt + ONE;
               end
            end
         end
         FLUSH: begin
            emit   = 1'b1;
            flush  = 1'b1;
            fcnt_n = fcnt + ONE;
            if (fcnt == DM1) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      bf_valid_n   = issue;
      dl_en_n      = issue | flush;
      tw_addr_n    = issue ? ((cnt & DM1) << STAGE) : '0;
      in_sw_sel_n  = issue & cnt[SB];
      out_valid_n  = emit;
      out_sw_sel_n = emit & j[SB];
      out_sop_n    = emit & (j == '0);
      out_last_n   = emit & (j == PM1);
      j_n          = emit ? (j + ONE) : j;
   end

   // All control outputs are registered so they line up with the datapath's registered pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         fill       <= '0;
         j          <= '0;
         fcnt       <= '0;
         bf_valid   <= 1'b0;
         tw_addr    <= '0;
         in_sw_sel  <= 1'b0;
         dl_en      <= 1'b0;
         out_valid  <= 1'b0;
         out_sop    <= 1'b0;
         out_last   <= 1'b0;
         out_sw_sel <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         fill       <= fill_n;
         j          <= j_n;
         fcnt       <= fcnt_n;
         bf_valid   <= bf_valid_n;
         tw_addr    <= tw_addr_n;
         in_sw_sel  <= in_sw_sel_n;
         dl_en      <= dl_en_n;
         out_valid  <= out_valid_n;
         out_sop    <= out_sop_n;
         out_last   <= out_last_n;
         out_sw_sel <= out_sw_sel_n;
         err        <= err_n;
      end
   end

endmodule

// File: tb/tb_r2mdc_stage_ctrl.sv
// Scoreboard bench for r2mdc_stage_ctrl: STAGE=1 (D=4) and STAGE=3 (D=1) instances with N=16;
// expected events are queued per scenario and matched by a negedge monitor.
module tb_r2mdc_stage_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic in_valid;
   logic in_sop;
   logic sel;
   logic v1, v3;

   logic       d1_ready, d1_bf, d1_isw, d1_dl, d1_ov, d1_osop, d1_olast, d1_osw, d1_err;
   logic [2:0] d1_tw;
   logic       d3_ready, d3_bf, d3_isw, d3_dl, d3_ov, d3_osop, d3_olast, d3_osw, d3_err;
   logic [2:0] d3_tw;

   logic       m_ready, m_bf, m_isw, m_dl, m_ov, m_osop, m_olast, m_osw, m_err;
   logic [2:0] m_tw;

   always #5 clk = ~clk;

   assign v1 = in_valid & ~sel;
   assign v3 = in_valid & sel;

   r2mdc_stage_ctrl #(.LOG2N(4), .STAGE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_sop(in_sop),
      .in_ready(d1_ready), .bf_valid(d1_bf), .tw_addr(d1_tw), .in_sw_sel(d1_isw),
      .dl_en(d1_dl), .out_valid(d1_ov), .out_sop(d1_osop), .out_last(d1_olast),
      .out_sw_sel(d1_osw), .err(d1_err)
   );

   r2mdc_stage_ctrl #(.LOG2N(4), .STAGE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_sop(in_sop),
      .in_ready(d3_ready), .bf_valid(d3_bf), .tw_addr(d3_tw), .in_sw_sel(d3_isw),
      .dl_en(d3_dl), .out_valid(d3_ov), .out_sop(d3_osop), .out_last(d3_olast),
      .out_sw_sel(d3_osw), .err(d3_err)
   );

   assign m_ready = sel ? d3_ready : d1_ready;
   assign m_bf    = sel ? d3_bf    : d1_bf;
   assign m_tw    = sel ? d3_tw    : d1_tw;
   assign m_isw   = sel ? d3_isw   : d1_isw;
   assign m_dl    = sel ? d3_dl    : d1_dl;
   assign m_ov    = sel ? d3_ov    : d1_ov;
   assign m_osop  = sel ? d3_osop  : d1_osop;
   assign m_olast = sel ? d3_olast : d1_olast;
   assign m_osw   = sel ? d3_osw   : d1_osw;
   assign m_err   = sel ? d3_err   : d1_err;

   typedef struct packed {
      int         c;
      logic [2:0] tw;
      logic       sw;
   } bf_t;

   typedef struct packed {
      int   c;
      logic sop;
      logic last;
      logic sw;
   } ov_t;

   bf_t bfq[$];
   ov_t ovq[$];
   int  dlq[$];
   int  rdyq[$];
   int  errq[$];

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;
   int t0     = 0;

   int twS1[8]   = '{0, 2, 4, 6, 0, 2, 4, 6};
   int swS1[8]   = '{0, 0, 0, 0, 1, 1, 1, 1};
   int swS3[8]   = '{0, 1, 0, 1, 0, 1, 0, 1};
   int bfCycG[8] = '{1, 2, 4, 5, 6, 8, 9, 10};
   int ovCycG[8] = '{6, 8, 9, 10, 11, 12, 13, 14};
   int dlCycG[12] = '{1, 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every presented event must match the head of its expectation queue.
   int  rel_m;
   int  ex_m;
   bf_t eb_m;
   ov_t eo_m;

   task automatic cmpCyc(input string nm, input int ex, input int act);
      tests++;
      if (ex != act) begin
         failed++;
         $display("[TB] FAIL %s: seen at cycle %0d, required cycle %0d (-1 = none expected)", nm, act, ex);
      end
   endtask

   always @(negedge clk) begin
      rel_m = cyc - t0;
      if (m_bf) begin
         tests++;
         if (bfq.size() == 0) begin
            failed++;
            $display("[TB] FAIL bf_valid: unexpected at cycle %0d tw=%0d sw=%0d", rel_m, m_tw, m_isw);
         end else begin
            eb_m = bfq.pop_front();
            if (eb_m.c != rel_m || eb_m.tw != m_tw || eb_m.sw != m_isw) begin
               failed++;
               $display("[TB] FAIL bf_valid: got cycle %0d tw=%0d sw=%0d, required cycle %0d tw=%0d sw=%0d",
                        rel_m, m_tw, m_isw, eb_m.c, eb_m.tw, eb_m.sw);
            end
         end
      end
      if (m_ov) begin
         tests++;
         if (ovq.size() == 0) begin
            failed++;
            $display("[TB] FAIL out_valid: unexpected at cycle %0d", rel_m);
         end else begin
            eo_m = ovq.pop_front();
            if (eo_m.c != rel_m || eo_m.sop != m_osop || eo_m.last != m_olast || eo_m.sw != m_osw) begin
               failed++;
               $display("[TB] FAIL out_valid: got cycle %0d sop=%0d last=%0d sw=%0d, required cycle %0d sop=%0d last=%0d sw=%0d",
                        rel_m, m_osop, m_olast, m_osw, eo_m.c, eo_m.sop, eo_m.last, eo_m.sw);
            end
         end
      end
      if (m_dl) begin
         ex_m = (dlq.size() > 0) ? dlq.pop_front() : -1;
         cmpCyc("dl_en", ex_m, rel_m);
      end
      if (!m_ready) begin
         ex_m = (rdyq.size() > 0) ? rdyq.pop_front() : -1;
         cmpCyc("in_ready_low", ex_m, rel_m);
      end
      if (m_err) begin
         ex_m = (errq.size() > 0) ? errq.pop_front() : -1;
         cmpCyc("err", ex_m, rel_m);
      end
   end

   task automatic pushBf(input int c, input int tw, input int sw);
      bf_t e;
      e.c = c; e.tw = 3'(tw); e.sw = sw[0];
      bfq.push_back(e);
   endtask

   task automatic pushOv(input int c, input logic sop, input logic last, input int sw);
      ov_t e;
      e.c = c; e.sop = sop; e.last = last; e.sw = sw[0];
      ovq.push_back(e);
   endtask

   task automatic expectContS1(input int nOut);
      for (int i = 0; i < 8; i++) pushBf(1 + i, twS1[i], swS1[i]);
      for (int i = 0; i < nOut; i++) pushOv(5 + i, i == 0, i == 7, swS1[i]);
      for (int i = 1; i <= 4 + nOut; i++) dlq.push_back(i);
   endtask

   task automatic applyStimulus(input logic v, input logic s);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sop   = s;
   endtask

   task automatic runFrame(input logic [15:0] vp, input logic [15:0] sp, input int len, input int tail);
      for (int i = 0; i < len; i++) begin
         applyStimulus(vp[i], sp[i]);
         if (i == 0) t0 = cyc;
      end
      for (int i = 0; i < tail; i++) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string scen);
      tests++;
      if (bfq.size() + ovq.size() + dlq.size() + rdyq.size() + errq.size() != 0) begin
         failed++;
         $display("[TB] FAIL %s: missing events bf=%0d ov=%0d dl=%0d rdy=%0d err=%0d, required all 0",
                  scen, bfq.size(), ovq.size(), dlq.size(), rdyq.size(), errq.size());
      end
      bfq.delete(); ovq.delete(); dlq.delete(); rdyq.delete(); errq.delete();
   endtask

   task automatic checkZero(input string nm);
      logic [19:0] regs;
      regs = {d1_bf, d1_tw, d1_isw, d1_dl, d1_ov, d1_osop, d1_olast, d1_osw, d1_err,
              d3_bf, d3_tw, d3_isw, d3_dl, d3_ov, d3_osop, d3_olast, d3_osw, d3_err};
      tests++;
      if (regs != '0 || d1_ready != 1'b1 || d3_ready != 1'b1) begin
         failed++;
         $display("[TB] FAIL %s: outputs=%h ready=%b%b, required outputs=0 ready=11",
                  nm, regs, d1_ready, d3_ready);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      sel      = 1'b0;
      #1 rst_n = 1'b0;

      // Reset held with random inputs.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         in_valid = 1'($urandom_range(0, 1));
         in_sop   = 1'($urandom_range(0, 1));
         sel      = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkZero("reset_hold");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      sel      = 1'b0;
      #1 rst_n = 1'b1;
      runFrame(16'h0000, 16'h0000, 1, 3);
      checkOutput("reset_release");

      // Continuous frame, STAGE=1.
      expectContS1(8);
      for (int c = 8; c <= 11; c++) rdyq.push_back(c);
      runFrame(16'h00FF, 16'h0001, 8, 8);
      checkOutput("continuous_s1");

      // Gaps on cycles 2 and 6.
      for (int i = 0; i < 8; i++) pushBf(bfCycG[i], twS1[i], swS1[i]);
      for (int i = 0; i < 8; i++) pushOv(ovCycG[i], i == 0, i == 7, swS1[i]);
      for (int i = 0; i < 12; i++) dlq.push_back(dlCycG[i]);
      for (int c = 10; c <= 13; c++) rdyq.push_back(c);
      runFrame(16'h03BB, 16'h0001, 10, 8);
      checkOutput("gaps_s1");

      // Data without sop in IDLE is dropped.
      errq.push_back(1);
      runFrame(16'h0001, 16'h0000, 1, 4);
      checkOutput("idle_no_sop");

      // Stray sop on the 3rd pair.
      expectContS1(8);
      for (int c = 8; c <= 11; c++) rdyq.push_back(c);
      errq.push_back(3);
      runFrame(16'h00FF, 16'h0005, 8, 8);
      checkOutput("sop_3rd_pair");

      // Async reset in the middle of FLUSH, then a clean frame.
      expectContS1(4);
      rdyq.push_back(8);
      runFrame(16'h00FF, 16'h0001, 9, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkZero("reset_mid_flush");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      runFrame(16'h0000, 16'h0000, 1, 2);
      checkOutput("reset_mid_flush_events");

      expectContS1(8);
      for (int c = 8; c <= 11; c++) rdyq.push_back(c);
      runFrame(16'h00FF, 16'h0001, 8, 8);
      checkOutput("after_reset_s1");

      // Continuous frame, STAGE=3 (D=1).
      sel = 1'b1;
      for (int i = 0; i < 8; i++) pushBf(1 + i, 0, swS3[i]);
      for (int i = 0; i < 8; i++) pushOv(2 + i, i == 0, i == 7, swS3[i]);
      for (int c = 1; c <= 9; c++) dlq.push_back(c);
      rdyq.push_back(8);
      runFrame(16'h00FF, 16'h0001, 8, 6);
      checkOutput("continuous_s3");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/r2mdc_stage_ctrl.md
Name: r2mdc_stage_ctrl

Overview:
- Per-stage sequencer for one R2MDC pipeline stage built around the combinational radix-2 butterfly (16-bit Q7.8 A/B/W in, Y0/Y1 out).
- Generates the input-pair handshake, the butterfly twiddle ROM address, the commutator selects and the delay-line shift enable.
- Frames output-valid, including the end-of-frame delay-line flush.
- One instance per stage; the datapath registers the accepted input pair once, and every control output is registered and aligned to that registered pair.

Parameters:
- LOG2N, 4, log2 of FFT length N; N = 2^LOG2N, P = N/2 pairs per frame.
- STAGE, 1, stage index; legal range 1..LOG2N-1. Derived D = 2^(LOG2N-STAGE-1) is the commutator half-period and delay depth, in pairs.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upper/lower input pair present.
- in_sop  in  1  first pair of a frame; qualified by in_valid.
- in_ready  out  1  stage accepts a pair this cycle.
- bf_valid  out  1  registered pair is being processed by the butterfly.
- tw_addr  out  LOG2N-1  twiddle ROM index k for W = W_N^k.
- in_sw_sel  out  1  input commutator select; 0 = straight, 1 = cross.
- dl_en  out  1  delay-line shift enable.
- out_valid  out  1  output pair valid.
- out_sop  out  1  first output pair of a frame.
- out_last  out  1  last output pair of a frame.
- out_sw_sel  out  1  output commutator select.
- err  out  1  one-cycle protocol error pulse.

Behaviour:
- Accept condition: accept = in_valid & in_ready.
- in_ready is combinational from state: 1 in IDLE, FILL and RUN; 0 in FLUSH. It is 1 while rst_n is low.
- Registered outputs: all other outputs are registered and clear to 0 asynchronously on rst_n low, and state returns to IDLE. Reset may occur mid-frame; no partial frame resumes afterwards.
- Counters:
  - cnt (LOG2N-1 bits): input pair index within the frame.
  - fill (0..D): number of pairs accepted so far, saturating at D.
  - j (LOG2N-1 bits): output pair index.
  - fcnt: flush counter.
- IDLE:
  - accept with in_sop: cnt <= 1, fill <= 1; go to RUN if D==1, else FILL.
  - accept without in_sop: pair dropped, err = 1 next cycle.
- FILL: each accept increments cnt and fill. On the accept that makes fill==D, go to RUN.
- RUN:
  - Each accept increments cnt.
  - The accept with cnt==P-1 goes to FLUSH with fcnt <= 0; cnt wraps to 0.
  - in_sop on any accept in FILL or RUN raises err and the pair is treated as data.
- FLUSH: in_ready=0. One internal shift per cycle for D cycles; then go to IDLE.
- Per-cycle outputs (registered, appear the cycle after the event):
  - For each accept, with c = cnt before increment:
    - bf_valid = 1
    - dl_en = 1
    - tw_addr = (c mod D) << STAGE
    - in_sw_sel = c[LOG2N-STAGE-1]
  - out_valid = 1:
    - for accepts made in RUN state, excluding the transitioning accept from FILL (for D==1, the first accept from IDLE is also excluded);
    - for every FLUSH cycle, which also forces dl_en = 1 and bf_valid = 0.
  - With each out_valid, out_sw_sel = j[LOG2N-STAGE-1]; then j increments, wrapping at P.
  - out_sop accompanies j==0; out_last accompanies j==P-1.
- Frame totals: exactly P out_valid per frame, P-D during RUN plus D during FLUSH.
- Latency: first out_valid comes D+1 accepted pairs after sop.
- Gaps: in_valid low in FILL or RUN produces no shift and no out_valid; cnt, tw_addr and in_sw_sel sequences are unaffected.
- Back-to-back frames: no output backpressure. The next sop is accepted no earlier than the first IDLE cycle after FLUSH.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> every registered output 0, in_ready=1; release -> IDLE, no err.
- Continuous frame with N=16, STAGE=1 (D=4, P=8), sop at cycle 0, in_valid cycles 0..7:
  - bf_valid cycles 1..8, tw_addr 0,2,4,6,0,2,4,6, in_sw_sel 0,0,0,0,1,1,1,1;
  - in_ready=0 cycles 8..11;
  - out_valid cycles 5..12, out_sop at 5, out_last at 12, out_sw_sel 0,0,0,0,1,1,1,1;
  - dl_en cycles 1..12.
- Gaps: same frame with in_valid low on cycles 2 and 6 -> tw_addr sequence unchanged, no dl_en or out_valid in the corresponding cycles, still 8 out_valid and out_last once.
- Protocol errors: in_valid without sop in IDLE -> err pulse, cnt stays 0; sop on the 3rd pair -> err pulse, frame completes normally.
- Async reset asserted mid-FLUSH -> outputs 0 immediately; new sop after release -> clean frame matching the continuous-frame scenario.
- STAGE=3 (D=1), continuous frame -> tw_addr all 0, in_sw_sel toggles 0,1,0,1,... every pair, first out_valid 2 cycles after sop, one FLUSH cycle, 8 out_valid.
